maxnet_feeder: RTL and testbench

Upstream sequencer for the Maxnet winner-take-all core. Accepts a stream of 5-bit activations over a valid/ready handshake and packs four of them into the core's parallel X1..X4 inputs. Issues a one-cycle start pulse and waits for the core's done. Captures the winning result and offers it downstream over a second valid/ready handshake. Sits between the sample source and the Maxnet instance, and owns all of the core's control inputs.

---
 rtl/maxnet_feeder.sv | 149 ++++++++++++++
 tb/tb_maxnet_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_feeder.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_feeder
// Purpose  : Packs four 5-bit activations into Maxnet X1..X4, pulses start,
//            waits for done and hands the captured result downstream.
// Options  : MAXNET_FEEDER_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles.
// Revision : 1.0  initial release
// ============================================================================
module maxnet_feeder #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] in_data,
    output logic       in_ready,
    output logic       mx_start,
    output logic [4:0] mx_x1,
    output logic [4:0] mx_x2,
    output logic [4:0] mx_x3,
    output logic [4:0] mx_x4,
    input  logic       mx_done,
    input  logic [4:0] mx_result,
    output logic       out_valid,
    output logic [4:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cnt;
    logic [4:0] r_x1, r_x2, r_x3, r_x4;
    logic [4:0] r_out_data;
    logic       w_accept;
    logic       w_capture;
    logic       w_expire;

    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_timeout_range
        $error("maxnet_feeder: TIMEOUT must lie in 2..1023");
    end

    assign w_accept  = (r_state == ST_LOAD) && in_valid;
    assign w_capture = (r_state == ST_WAIT) && mx_done;

`ifdef MAXNET_FEEDER_TIMEOUT_EN
    localparam int                c_TW   = $clog2(TIMEOUT);
    localparam logic [c_TW-1:0]   c_LAST = c_TW'(TIMEOUT - 1);

    logic [c_TW-1:0] r_wcnt;
    logic            r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= '0;
        end else if (r_state == ST_FIRE) begin
            r_wcnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wcnt <= r_wcnt + c_TW'(1);
        end
    end

    // A done arriving on the expiry cycle wins over the abort.
    assign w_expire = (r_state == ST_WAIT) && !mx_done && (r_wcnt == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end else if ((r_state == ST_OUT) && out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD: if (w_accept && (r_cnt == 2'd3)) w_next = ST_FIRE;
            ST_FIRE: w_next = ST_WAIT;
            ST_WAIT: if (w_capture || w_expire) w_next = ST_OUT;
            ST_OUT:  if (out_ready) w_next = ST_LOAD;
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 2'd0;
            r_x1       <= 5'd0;
            r_x2       <= 5'd0;
            r_x3       <= 5'd0;
            r_x4       <= 5'd0;
            r_out_data <= 5'd0;
        end else begin
            if (w_accept) begin
                case (r_cnt)
                    2'd0:    r_x1 <= in_data;
                    2'd1:    r_x2 <= in_data;
                    2'd2:    r_x3 <= in_data;
                    default: r_x4 <= in_data;
                endcase
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_capture) begin
                r_out_data <= mx_result;
            end else if (w_expire) begin
                r_out_data <= 5'd0;
            end
        end
    end

    // Control outputs are pure state decodes so reset clears them immediately.
    assign in_ready  = (r_state == ST_LOAD);
    assign mx_start  = (r_state == ST_FIRE);
    assign busy      = (r_state == ST_FIRE) || (r_state == ST_WAIT);
    assign out_valid = (r_state == ST_OUT);
    assign out_data  = r_out_data;
    assign mx_x1     = r_x1;
    assign mx_x2     = r_x2;
    assign mx_x3     = r_x3;
    assign mx_x4     = r_x4;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxnet_feeder
// Purpose  : Directed self-checking bench for maxnet_feeder; the Maxnet core
//            is modelled by driving mx_done/mx_result from each scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_maxnet_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = 5'd0;
    logic       in_ready;
    logic       mx_start;
    logic [4:0] mx_x1, mx_x2, mx_x3, mx_x4;
    logic       mx_done = 1'b0;
    logic [4:0] mx_result = 5'd0;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int cap_cnt   = 0;
    logic ov_q = 1'b0;

    maxnet_feeder #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mx_start  (mx_start),
        .mx_x1     (mx_x1),
        .mx_x2     (mx_x2),
        .mx_x3     (mx_x3),
        .mx_x4     (mx_x4),
        .mx_done   (mx_done),
        .mx_result (mx_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count start pulses and out_valid frames (rising edges) as seen mid-cycle.
    always @(negedge clk) begin
        if (mx_start === 1'b1) start_cnt <= start_cnt + 1;
        if (out_valid === 1'b1 && ov_q !== 1'b1) cap_cnt <= cap_cnt + 1;
        ov_q <= out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL push_wait: in_ready never rose for word %0d", d);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        n_cmp++; if (mx_start !== 1'b0) begin n_fail++; $display("FAIL rst_mx_start got=%0b exp=0", mx_start); end
        n_cmp++; if ({mx_x1, mx_x2, mx_x3, mx_x4} !== 20'd0) begin n_fail++; $display("FAIL rst_mx_x got=%0h exp=0", {mx_x1, mx_x2, mx_x3, mx_x4}); end
        n_cmp++; if ({out_valid, busy, err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%03b exp=000", {out_valid, busy, err}); end
        n_cmp++; if (out_data !== 5'd0) begin n_fail++; $display("FAIL rst_out_data got=%0d exp=0", out_data); end
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int s0 = start_cnt;
        int c0 = cap_cnt;
        push(5'd3); push(5'd17); push(5'd9); push(5'd12);
        n_cmp++; if (mx_start !== 1'b1) begin n_fail++; $display("FAIL sf_start got=%0b exp=1", mx_start); end
        n_cmp++; if ({mx_x1, mx_x2, mx_x3, mx_x4} !== {5'd3, 5'd17, 5'd9, 5'd12})
            begin n_fail++; $display("FAIL sf_x got=%0d,%0d,%0d,%0d exp=3,17,9,12", mx_x1, mx_x2, mx_x3, mx_x4); end
        n_cmp++; if ({in_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL sf_fire_flags got=%02b exp=01", {in_ready, busy}); end
        tick();
        n_cmp++; if ({mx_start, busy, out_valid} !== 3'b010) begin n_fail++; $display("FAIL sf_wait_flags got=%03b exp=010", {mx_start, busy, out_valid}); end
        mx_done = 1'b1; mx_result = 5'd17;
        tick();
        mx_done = 1'b0;
        n_cmp++; if ({out_valid, out_data, err, busy} !== {1'b1, 5'd17, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL sf_out got=v%0b d%0d e%0b b%0b exp=v1 d17 e0 b0", out_valid, out_data, err, busy); end
        release_out();
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL sf_back_to_load got=%02b exp=10", {in_ready, out_valid}); end
        n_cmp++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL sf_start_count got=%0d exp=1", start_cnt - s0); end
        n_cmp++; if (cap_cnt - c0 !== 1) begin n_fail++; $display("FAIL sf_capture_count got=%0d exp=1", cap_cnt - c0); end
    endtask

    task automatic test_backpressure();
        int c0 = cap_cnt;
        push(5'd3); tick(); tick();
        push(5'd17); tick();
        push(5'd9); tick(); tick(); tick();
        push(5'd12);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_fire_in_ready got=%0b exp=0", in_ready); end
        in_valid = 1'b1; in_data = 5'd25;
        tick(); tick();
        n_cmp++; if ({in_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL bp_wait got=%02b exp=01", {in_ready, busy}); end
        mx_done = 1'b1; mx_result = 5'd17;
        tick();
        mx_done = 1'b0; mx_result = 5'd2;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, 5'd17})
                begin n_fail++; $display("FAIL bp_hold[%0d] got=v%0b r%0b d%0d exp=v1 r0 d17", i, out_valid, in_ready, out_data); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (mx_x1 !== 5'd3) begin n_fail++; $display("FAIL bp_no_accept got=%0d exp=3", mx_x1); end
        release_out();
        tick();
        n_cmp++; if (cap_cnt - c0 !== 1) begin n_fail++; $display("FAIL bp_capture_count got=%0d exp=1", cap_cnt - c0); end
    endtask

    task automatic test_back_to_back();
        push(5'd3); push(5'd17); push(5'd9); push(5'd12);
        tick();
        mx_done = 1'b1; mx_result = 5'd17;
        tick();
        mx_done = 1'b0;
        in_valid = 1'b1; in_data = 5'd1;
        tick(); tick(); tick();
        n_cmp++; if ({out_valid, in_ready, mx_x1} !== {1'b1, 1'b0, 5'd3})
            begin n_fail++; $display("FAIL b2b_stall got=v%0b r%0b x1=%0d exp=v1 r0 x1=3", out_valid, in_ready, mx_x1); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if ({in_ready, mx_x1} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL b2b_reopen got=r%0b x1=%0d exp=r1 x1=3", in_ready, mx_x1); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({mx_x1, mx_x2} !== {5'd1, 5'd17}) begin n_fail++; $display("FAIL b2b_partial got=%0d,%0d exp=1,17", mx_x1, mx_x2); end
        push(5'd2); push(5'd3); push(5'd31);
        n_cmp++; if ({mx_start, mx_x1, mx_x2, mx_x3, mx_x4} !== {1'b1, 5'd1, 5'd2, 5'd3, 5'd31})
            begin n_fail++; $display("FAIL b2b_fire got=s%0b %0d,%0d,%0d,%0d exp=s1 1,2,3,31", mx_start, mx_x1, mx_x2, mx_x3, mx_x4); end
        tick(); tick();
        mx_done = 1'b1; mx_result = 5'd31;
        tick();
        mx_done = 1'b0;
        n_cmp++; if ({out_valid, out_data} !== {1'b1, 5'd31}) begin n_fail++; $display("FAIL b2b_result got=v%0b d%0d exp=v1 d31", out_valid, out_data); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int s0 = start_cnt;
        push(5'd10); push(5'd11);
        rst = 1'b0;
        #1;
        n_cmp++; if ({in_ready, mx_x1, mx_x2} !== {1'b1, 5'd0, 5'd0})
            begin n_fail++; $display("FAIL rm_clear got=r%0b %0d,%0d exp=r1 0,0", in_ready, mx_x1, mx_x2); end
        tick();
        rst = 1'b1;
        push(5'd5); push(5'd6); push(5'd7); push(5'd8);
        n_cmp++; if ({mx_start, mx_x1, mx_x2, mx_x3, mx_x4} !== {1'b1, 5'd5, 5'd6, 5'd7, 5'd8})
            begin n_fail++; $display("FAIL rm_fire got=s%0b %0d,%0d,%0d,%0d exp=s1 5,6,7,8", mx_start, mx_x1, mx_x2, mx_x3, mx_x4); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({mx_start, busy, in_ready} !== 3'b001) begin n_fail++; $display("FAIL rm_async_start got=%03b exp=001", {mx_start, busy, in_ready}); end
        tick();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL rm_start_count got=%0d exp=1", start_cnt - s0); end
        n_cmp++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL rm_idle got=%02b exp=00", {busy, out_valid}); end
    endtask

    task automatic test_done_held();
        int c0 = cap_cnt;
        push(5'd4); push(5'd30); push(5'd2); push(5'd7);
        tick();
        mx_done = 1'b1; mx_result = 5'd30;
        tick();
        mx_result = 5'd9;
        tick(); tick();
        n_cmp++; if ({out_valid, out_data} !== {1'b1, 5'd30}) begin n_fail++; $display("FAIL dh_hold got=v%0b d%0d exp=v1 d30", out_valid, out_data); end
        release_out();
        mx_done = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL dh_after got=%03b exp=010", {out_valid, in_ready, busy}); end
        n_cmp++; if (cap_cnt - c0 !== 1) begin n_fail++; $display("FAIL dh_capture_count got=%0d exp=1", cap_cnt - c0); end
    endtask

`ifdef MAXNET_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        push(5'd1); push(5'd2); push(5'd3); push(5'd4);
        tick();
        repeat (7) tick();
        n_cmp++; if ({busy, out_valid} !== 2'b10) begin n_fail++; $display("FAIL to_wait8 got=%02b exp=10", {busy, out_valid}); end
        tick();
        n_cmp++; if ({out_valid, out_data, err} !== {1'b1, 5'd0, 1'b1})
            begin n_fail++; $display("FAIL to_abort got=v%0b d%0d e%0b exp=v1 d0 e1", out_valid, out_data, err); end
        release_out();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got=%0b exp=0", err); end
        push(5'd1); push(5'd2); push(5'd3); push(5'd4);
        tick();
        repeat (7) tick();
        mx_done = 1'b1; mx_result = 5'd22;
        tick();
        mx_done = 1'b0;
        n_cmp++; if ({out_valid, out_data, err} !== {1'b1, 5'd22, 1'b0})
            begin n_fail++; $display("FAIL to_done_wins got=v%0b d%0d e%0b exp=v1 d22 e0", out_valid, out_data, err); end
        release_out();
    endtask
`else
    task automatic test_wait_forever();
        push(5'd1); push(5'd2); push(5'd3); push(5'd4);
        tick();
        repeat (100) tick();
        n_cmp++; if ({busy, out_valid, err} !== 3'b100) begin n_fail++; $display("FAIL wf_still_waiting got=%03b exp=100", {busy, out_valid, err}); end
        mx_done = 1'b1; mx_result = 5'd4;
        tick();
        mx_done = 1'b0;
        n_cmp++; if ({out_valid, out_data, err} !== {1'b1, 5'd4, 1'b0})
            begin n_fail++; $display("FAIL wf_result got=v%0b d%0d e%0b exp=v1 d4 e0", out_valid, out_data, err); end
        release_out();
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_done_held();
`ifdef MAXNET_FEEDER_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
